gpio_cfg_sequencer: RTL and testbench
=====================================

Name: gpio_cfg_sequencer

Overview:
- Runtime, parametrised replacement for per-pad constant Config_access INIT values.
- Holds one CFG_BITS-wide GPIO mode word per pad in a writable register file and validates each write against the legal mode set.
- On command, serialises all mode words followed by the config-done sequence onto a shift chain, then pulses a load strobe.
- Sits between the fabric control logic (or the management interface) and the pad-configuration shift chain.

Parameters:
- NUM_PADS, 30, number of pads on the chain (18 UIO + 12 fabric IO); must be at least 1.
- CFG_BITS, 12, mode bits per pad.
- DONE_BITS, 48, length of the config-done sequence.
- DONE_SEQ, 48'hFEEDBADCA77E, config-done sequence shifted after the last pad.
- DEFAULT_MODE, 12'h4C1, reset and substitute mode (GPIO_MODE_INPUT).
- AW, $clog2(NUM_PADS) with minimum 1, pad address width.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en_i  in  1  mode-write strobe.
- wr_addr_i  in  AW  pad index of the write.
- wr_mode_i  in  CFG_BITS  mode word to write.
- rd_addr_i  in  AW  readback pad index.
- rd_mode_o  out  CFG_BITS  registered readback word.
- start_i  in  1  begin serialisation.
- abort_i  in  1  cancel serialisation.
- cfg_sdo_o  out  1  serial data, MSB first.
- cfg_shift_o  out  1  high in every cycle in which cfg_sdo_o is a valid chain bit.
- cfg_load_o  out  1  one-cycle latch pulse.
- busy_o  out  1  high while a sequence is in progress.
- done_o  out  1  sticky; a complete sequence has been loaded.
- err_o  out  1  sticky; an illegal mode write or a write during busy occurred.
- err_clr_i  in  1  clears err_o.

Behaviour:
- Reset:
  - All mode registers are set to DEFAULT_MODE.
  - rd_mode_o = DEFAULT_MODE.
  - All other outputs are 0; the FSM is in IDLE.
- Legal modes: 2C6, 4C1, 9C2, 1C3, 006, 003, 002, 386, B86 (hex, CFG_BITS=12).
- Writes:
  - Writes are accepted only in IDLE.
  - Legal word: stored at the next edge.
  - Illegal word: DEFAULT_MODE is stored and err_o is set.
  - Write while busy_o=1: dropped, err_o is set.
  - Write with wr_addr_i >= NUM_PADS: dropped, err_o is set.
- Readback:
  - rd_mode_o = mem[rd_addr_i], registered with 1-cycle latency.
  - A same-cycle write to the same address returns the new value one cycle later (write-first).
  - Out-of-range rd_addr_i returns 0.
- err_o:
  - err_clr_i clears it at the next edge.
  - If err_clr_i and a new error occur in the same cycle, the error wins and err_o stays 1.
- FSM states: IDLE, SHIFT_PADS, SHIFT_DONE, LOAD.
- IDLE:
  - start_i=1 moves the FSM to SHIFT_PADS and clears done_o.
  - busy_o goes to 1 in the next cycle.
  - If start_i and wr_en_i are asserted together, the write takes effect and is shifted in this sequence.
- SHIFT_PADS:
  - Order is pad NUM_PADS-1 first, down to pad 0; each word is sent MSB first.
  - One bit per cycle, with cfg_shift_o=1.
  - Lasts NUM_PADS*CFG_BITS cycles, tracked by a bit counter and a pad counter.
  - The first bit appears in the cycle after start_i is accepted.
- SHIFT_DONE: DONE_SEQ is shifted MSB first over DONE_BITS cycles, with cfg_shift_o=1.
- LOAD:
  - cfg_load_o=1 for exactly one cycle; cfg_shift_o=0.
  - In the following cycle: busy_o=0, done_o=1, FSM in IDLE.
- Total: start accepted at edge T; the load pulse occurs in cycle T+1+NUM_PADS*CFG_BITS+DONE_BITS.
- start_i while busy is ignored (no restart, no error).
- abort_i while busy:
  - At the next edge the FSM returns to IDLE and all strobes go to 0.
  - No load pulse is issued and done_o stays 0.
  - abort_i has priority over a LOAD transition in the same cycle.
  - abort_i in IDLE has no effect.
- While the FSM is not shifting, cfg_sdo_o is held at 0.
- Mode registers are not modified by a sequence.
- Reset asserted mid-sequence:
  - Everything returns to reset values at the next edge.
  - No load pulse is issued.
  - Mode registers revert to DEFAULT_MODE.

Test Plan:
- Reset values: assert rst for 2 cycles, then read pads 0..NUM_PADS-1 -> each rd_mode_o = 12'h4C1; all strobes and flags 0.
- Full sequence (NUM_PADS=2): write pad1=12'h2C6 and pad0=12'hB86, pulse start.
  - Captured bits on cfg_shift_o = 0x2C6, 0xB86, 0xFEEDBADCA77E (72 bits).
  - cfg_load_o pulses at start+1+72 cycles; then done_o=1 and busy_o=0.
- Illegal write: write 12'h123 to pad 0 -> err_o=1 and readback 12'h4C1; err_clr_i -> err_o=0.
- Busy protection: write during SHIFT_PADS -> dropped and err_o=1; serial stream unchanged; a start_i pulse mid-sequence does not restart.
- Abort: abort_i at bit 20 -> busy_o=0 next cycle, no cfg_load_o, done_o=0; a new start runs a full 72-bit sequence.
- Reset mid-sequence: rst at bit 30 -> no load pulse; all mode registers read back 12'h4C1.

Source files
------------

// File: rtl/gpio_cfg_sequencer.sv
// Per-pad GPIO mode register file with legality checking, plus a serialiser that streams
// every mode word (highest pad first, MSB first) and the config-done sequence, then strobes a load.
module gpio_cfg_sequencer #(
   parameter int                   NUM_PADS     = 30,
   parameter int                   CFG_BITS     = 12,
   parameter int                   DONE_BITS    = 48,
   parameter logic [DONE_BITS-1:0] DONE_SEQ     = 48'hFEEDBADCA77E,
   parameter logic [CFG_BITS-1:0]  DEFAULT_MODE = 12'h4C1,
   parameter int                   AW           = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [CFG_BITS-1:0] wr_mode_i,
   input  logic [AW-1:0]       rd_addr_i,
   output logic [CFG_BITS-1:0] rd_mode_o,
   input  logic                start_i,
   input  logic                abort_i,
   output logic                cfg_sdo_o,
   output logic                cfg_shift_o,
   output logic                cfg_load_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o,
   input  logic                err_clr_i
);

   localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
   localparam int DW = (DONE_BITS > 1) ? $clog2(DONE_BITS) : 1;
   localparam logic [AW:0] NUM_PADS_W = (AW+1)'(NUM_PADS);

   localparam int NUM_LEGAL = 9;
   localparam logic [NUM_LEGAL-1:0][11:0] LEGAL_MODES = {
      12'h2C6, 12'h4C1, 12'h9C2, 12'h1C3, 12'h006,
      12'h003, 12'h002, 12'h386, 12'hB86
   };

   typedef enum logic [1:0] {IDLE, SHIFT_PADS, SHIFT_DONE, LOAD} state_t;

   state_t              state, state_next;
   logic [CFG_BITS-1:0] mem [NUM_PADS];
   logic [AW-1:0]       pad_cnt;
   logic [BW-1:0]       bit_cnt;
   logic [DW-1:0]       done_cnt;

   function automatic logic is_legal(input logic [CFG_BITS-1:0] mode);
      is_legal = 1'b0;
      for (int i = 0; i < NUM_LEGAL; i++)
         if (mode == CFG_BITS'(LEGAL_MODES[i])) is_legal = 1'b1;
   endfunction

   logic                idle;
   logic                wr_in_range, rd_in_range, wr_legal, wr_ok, wr_err, start_go;
   logic [CFG_BITS-1:0] wr_word;

   assign idle        = (state == IDLE);
   assign wr_in_range = ({1'b0, wr_addr_i} < NUM_PADS_W);
   assign rd_in_range = ({1'b0, rd_addr_i} < NUM_PADS_W);
   assign wr_legal    = is_legal(wr_mode_i);
   assign wr_ok       = wr_en_i && idle && wr_in_range;
   assign wr_err      = wr_en_i && (!idle || !wr_in_range || !wr_legal);
   assign wr_word     = wr_legal ? wr_mode_i : DEFAULT_MODE;
   assign start_go    = idle && start_i;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: defaulting every combinational output first keeps all paths assigned (no latches).
      state_next = state;
      case (state)
         IDLE:       if (start_i) state_next = SHIFT_PADS;
         SHIFT_PADS: if (bit_cnt == '0 && pad_cnt == '0) state_next = SHIFT_DONE;
         SHIFT_DONE: if (done_cnt == '0) state_next = LOAD;
         LOAD:       state_next = IDLE;
         default:    state_next = IDLE;
      endcase
      // Abort beats every busy transition, including the one into LOAD.
      if (abort_i && state != IDLE) state_next = IDLE;
   end

   always_comb begin
      cfg_shift_o = 1'b0;
      cfg_sdo_o   = 1'b0;
      cfg_load_o  = 1'b0;
      busy_o      = 1'b1;
      case (state)
         IDLE:       busy_o = 1'b0;
         SHIFT_PADS: begin
            cfg_shift_o = 1'b1;
            cfg_sdo_o   = mem[pad_cnt][bit_cnt];
         end
         SHIFT_DONE: begin
            cfg_shift_o = 1'b1;
            cfg_sdo_o   = DONE_SEQ[done_cnt];
         end
         LOAD:       cfg_load_o = 1'b1;
         default:    busy_o = 1'b0;
      endcase
   end

   // Counters are re-armed on every idle cycle so a start always begins at the top pad's MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         pad_cnt  <= '0;
         bit_cnt  <= '0;
         done_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               pad_cnt  <= AW'(NUM_PADS - 1);
               bit_cnt  <= BW'(CFG_BITS - 1);
               done_cnt <= DW'(DONE_BITS - 1);
            end
            SHIFT_PADS: begin
               if (bit_cnt == '0) begin
                  bit_cnt <= BW'(CFG_BITS - 1);
                  pad_cnt <= pad_cnt - AW'(1);
               end else begin
                  bit_cnt <= bit_cnt - BW'(1);
               end
            end
            SHIFT_DONE: done_cnt <= done_cnt - DW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: the mode file is reset explicitly because reset must restore DEFAULT_MODE in every pad.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PADS; i++) mem[i] <= DEFAULT_MODE;
      end else if (wr_ok) begin
         mem[wr_addr_i] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_mode_o <= DEFAULT_MODE;
         err_o     <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         if (!rd_in_range)                      rd_mode_o <= '0;
         else if (wr_ok && wr_addr_i == rd_addr_i) rd_mode_o <= wr_word;
         else                                   rd_mode_o <= mem[rd_addr_i];

         if (wr_err)         err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;

         if (start_go)                        done_o <= 1'b0;
         else if (state == LOAD && !abort_i)  done_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gpio_cfg_sequencer.sv
// Randomised bench for gpio_cfg_sequencer: a sequence-position model compared every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_gpio_cfg_sequencer;

   localparam int NP    = 3;
   localparam int CB    = 12;
   localparam int DB    = 48;
   localparam int TOTAL = NP * CB + DB;

   logic        clk = 1'b0;
   logic        rst, wr_en, start, abort, err_clr;
   logic [1:0]  wr_addr, rd_addr;
   logic [11:0] wr_mode;
   logic [11:0] rd_mode_o;
   logic        cfg_sdo_o, cfg_shift_o, cfg_load_o, busy_o, done_o, err_o;

   gpio_cfg_sequencer #(.NUM_PADS(NP)) dut (
      .clk(clk), .rst(rst),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_mode_i(wr_mode),
      .rd_addr_i(rd_addr), .rd_mode_o(rd_mode_o),
      .start_i(start), .abort_i(abort),
      .cfg_sdo_o(cfg_sdo_o), .cfg_shift_o(cfg_shift_o), .cfg_load_o(cfg_load_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_clr_i(err_clr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: mode array, sticky flags, and an integer position within the
   // current sequence (-1 = idle, 0..TOTAL-1 = chain bit, TOTAL = load cycle).
   logic [11:0] legal_list [9] = '{12'h2C6, 12'h4C1, 12'h9C2, 12'h1C3, 12'h006,
                                   12'h003, 12'h002, 12'h386, 12'hB86};
   logic [47:0] dseq = 48'hFEEDBADCA77E;
   logic [11:0] m_mem [NP];
   logic [11:0] m_rd;
   bit          m_err, m_done, m_valid;
   int          m_pos = -1;
   bit          m_stream [$];

   function automatic bit m_legal(input logic [11:0] v);
      foreach (legal_list[i]) if (legal_list[i] == v) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      bit          busy, new_err;
      logic [11:0] v;
      m_valid = 1'b1;
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] = 12'h4C1;
         m_rd = 12'h4C1; m_err = 0; m_done = 0; m_pos = -1;
         return;
      end
      busy    = (m_pos >= 0);
      new_err = 0;
      if (wr_en) begin
         if (busy || int'(wr_addr) >= NP) new_err = 1;
         else begin
            v = m_legal(wr_mode) ? wr_mode : 12'h4C1;
            if (!m_legal(wr_mode)) new_err = 1;
            m_mem[wr_addr] = v;
         end
      end
      m_rd = (int'(rd_addr) < NP) ? m_mem[rd_addr] : 12'h000;
      if (new_err) m_err = 1;
      else if (err_clr) m_err = 0;
      if (!busy) begin
         if (start) begin
            m_done = 0;
            m_stream.delete();
            for (int p = NP - 1; p >= 0; p--)
               for (int b = CB - 1; b >= 0; b--) m_stream.push_back(m_mem[p][b]);
            for (int b = DB - 1; b >= 0; b--) m_stream.push_back(dseq[b]);
            m_pos = 0;
         end
      end else if (abort) m_pos = -1;
      else if (m_pos == TOTAL) begin
         m_pos  = -1;
         m_done = 1;
      end else m_pos++;
   endtask

   always @(negedge clk) begin
      bit e_busy, e_shift, e_sdo, e_load;
      if (m_valid) begin
         e_busy  = (m_pos >= 0);
         e_shift = (m_pos >= 0) && (m_pos < TOTAL);
         e_sdo   = e_shift ? m_stream[m_pos] : 1'b0;
         e_load  = (m_pos == TOTAL);
         check("busy",  busy_o,      e_busy);
         check("shift", cfg_shift_o, e_shift);
         check("sdo",   cfg_sdo_o,   e_sdo);
         check("load",  cfg_load_o,  e_load);
         check("done",  done_o,      m_done);
         check("err",   err_o,       m_err);
         check("rd",    rd_mode_o,   m_rd);
      end
   end

   // Serial capture, sampled just after each edge.
   bit           cap_en;
   logic [127:0] cap;
   int           cap_n;

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      if (cap_en && cfg_shift_o) begin
         cap = {cap[126:0], cfg_sdo_o};
         cap_n++;
      end
   endtask

   task automatic cap_reset();
      cap = '0; cap_n = 0; cap_en = 1'b1;
   endtask

   task automatic write(input logic [1:0] a, input logic [11:0] m);
      wr_en = 1; wr_addr = a; wr_mode = m;
      cycle();
      wr_en = 0;
   endtask

   task automatic pulse_start();
      start = 1;
      cycle();
      start = 0;
   endtask

   task automatic run_until_load(output int k);
      k = 0;
      while (!cfg_load_o && k < 400) begin
         cycle();
         k++;
      end
      check("load_seen", cfg_load_o, 1'b1);
   endtask

   task automatic watch_no_load(input string name, input int n);
      bit saw = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         if (cfg_load_o) saw = 1;
      end
      check(name, saw, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      logic [127:0] exp1 = {44'd0, 12'h4C1, 12'h2C6, 12'hB86, 48'hFEEDBADCA77E};
      logic [127:0] exp2 = {44'd0, 12'h4C1, 12'h2C6, 12'h4C1, 48'hFEEDBADCA77E};

      rst = 1; wr_en = 0; wr_addr = 0; wr_mode = 0; rd_addr = 0;
      start = 0; abort = 0; err_clr = 0; cap_en = 0; cap = '0; cap_n = 0;
      cycle(); cycle();
      rst = 0;

      // Reset values
      check("rst_rd",    rd_mode_o, 12'h4C1);
      check("rst_busy",  busy_o,    1'b0);
      check("rst_flags", {done_o, err_o, cfg_shift_o, cfg_load_o, cfg_sdo_o}, 5'b0);
      for (int p = 0; p < NP; p++) begin
         rd_addr = 2'(p);
         cycle();
         check($sformatf("rst_rd_pad%0d", p), rd_mode_o, 12'h4C1);
      end
      rd_addr = 2'd3;
      cycle();
      check("rd_out_of_range", rd_mode_o, 12'h000);

      // Full sequence: load sits 1 + NP*CB + DB cycles after the start cycle
      write(2'd1, 12'h2C6);
      write(2'd0, 12'hB86);
      cap_reset();
      pulse_start();
      run_until_load(k);
      check("load_latency", k, 84);
      cycle();
      check("seq_done", {done_o, busy_o}, 2'b10);
      check("seq_bits", cap_n, 84);
      check("seq_stream", cap, exp1);

      // Illegal write is replaced by the default and flagged; write-first readback
      rd_addr = 2'd0;
      write(2'd0, 12'h123);
      check("illegal_err", err_o, 1'b1);
      check("illegal_rd", rd_mode_o, 12'h4C1);
      err_clr = 1;
      cycle();
      err_clr = 0;
      check("err_clear", err_o, 1'b0);

      // Out-of-range write dropped
      write(2'd3, 12'h2C6);
      check("oor_write_err", err_o, 1'b1);
      err_clr = 1; cycle(); err_clr = 0;

      // Busy protection: write dropped, mid-sequence start ignored
      cap_reset();
      pulse_start();
      repeat (5) cycle();
      write(2'd2, 12'h9C2);
      check("busy_write_err", err_o, 1'b1);
      pulse_start();
      run_until_load(k);
      check("busy_no_restart", k, 84 - 7);
      cycle();
      check("busy_stream", cap, exp2);
      rd_addr = 2'd2;
      cycle();
      check("busy_pad2", rd_mode_o, 12'h4C1);
      err_clr = 1; cycle(); err_clr = 0;

      // Abort around bit 20
      cap_reset();
      pulse_start();
      repeat (19) cycle();
      abort = 1;
      cycle();
      abort = 0;
      check("abort_busy", busy_o, 1'b0);
      check("abort_shift", cfg_shift_o, 1'b0);
      watch_no_load("abort_no_load", 100);
      check("abort_done", done_o, 1'b0);
      cap_reset();
      pulse_start();
      run_until_load(k);
      check("restart_latency", k, 84);
      check("restart_bits", cap_n, 84);
      cycle();
      check("restart_done", done_o, 1'b1);

      // Reset mid-sequence
      write(2'd1, 12'h386);
      pulse_start();
      repeat (30) cycle();
      rst = 1;
      cycle();
      rst = 0;
      check("rstmid_busy", busy_o, 1'b0);
      watch_no_load("rstmid_no_load", 100);
      for (int p = 0; p < NP; p++) begin
         rd_addr = 2'(p);
         cycle();
         check($sformatf("rstmid_pad%0d", p), rd_mode_o, 12'h4C1);
      end
      cap_en = 0;

      // Randomised traffic checked against the model every cycle
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 999) == 0);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_mode = ($urandom_range(0, 1) == 1) ? legal_list[$urandom_range(0, 8)] : 12'($urandom);
         rd_addr = 2'($urandom_range(0, 3));
         start   = ($urandom_range(0, 29) == 0);
         abort   = ($urandom_range(0, 199) == 0);
         err_clr = ($urandom_range(0, 15) == 0);
         cycle();
      end
      rst = 0; wr_en = 0; start = 0; abort = 0; err_clr = 0;
      cycle();
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
